// File: rtl/alu_seq.sv
// alu_seq: multi-precision ADD/SUB/ADDX/SUBX sequencer built around a single
// registered HALF-bit add stage. Long operations take two passes, low half
// first, with the carry or borrow chained from the low pass into the high pass.
//
// Handshake: REQ is sampled only while the block is IDLE. The edge where it is
// seen high is the accept edge, and A, B, OP, SIZE, XIN and ZIN are latched on
// that edge. BUSY is high from the next cycle until the cycle after DONE.
// DONE is a one-cycle pulse, and in that cycle O and the flags are final.
// Requests are never queued. RESET overrides everything, including a REQ in
// the same cycle.
module alu_seq #(
    parameter int HALF = 16
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                REQ,
    input  logic [1:0]          OP,
    input  logic                SIZE,
    input  logic [2*HALF-1:0]   A,
    input  logic [2*HALF-1:0]   B,
    input  logic                XIN,
    input  logic                ZIN,
    output logic                BUSY,
    output logic                DONE,
    output logic [2*HALF-1:0]   O,
    output logic                C,
    output logic                X,
    output logic                Z,
    output logic                V,
    output logic                N,
    output logic [1:0]          dbg_state
);

    localparam int W = 2 * HALF;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LO   = 2'd1,
        S_HI   = 2'd2,
        S_FIN  = 2'd3
    } state_t;

    state_t          state;
    logic [1:0]      op_q;
    logic            size_q;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic            xin_q;
    logic            zin_q;
    logic [HALF:0]   lo_q;     // low-pass sum, including its carry out

    // Datapath signals for the single shared adder
    logic            is_sub;
    logic            is_ext;
    logic [W-1:0]    b_eff;
    logic            cin0;
    logic            in_hi;
    logic [HALF-1:0] add_a;
    logic [HALF-1:0] add_b;
    logic            add_c;
    logic [HALF:0]   sum;
    logic [W-1:0]    res;
    logic            res_zero;
    logic            c_flag;
    logic            v_flag;
    logic            z_flag;

    assign dbg_state = state;

    // Operand selection for the current pass plus the flags of the final pass.
    // The pass that finishes the operation (LO for word, HI for long) always
    // holds the result MSB, so N, V and C come straight from the adder.
    always_comb begin
        is_sub   = op_q[0];
        is_ext   = op_q[1];
        b_eff    = is_sub ? ~b_q : b_q;
        // ADD 0, SUB 1, ADDX XIN, SUBX ~XIN
        cin0     = is_ext ? (xin_q ^ is_sub) : is_sub;
        in_hi    = (state == S_HI);
        add_a    = in_hi ? a_q[W-1:HALF]   : a_q[HALF-1:0];
        add_b    = in_hi ? b_eff[W-1:HALF] : b_eff[HALF-1:0];
        add_c    = in_hi ? lo_q[HALF]      : cin0;
        sum      = {1'b0, add_a} + {1'b0, add_b} + {{HALF{1'b0}}, add_c};
        res      = in_hi ? {sum[HALF-1:0], lo_q[HALF-1:0]}
                         : {{HALF{1'b0}}, sum[HALF-1:0]};
        res_zero = (sum[HALF-1:0] == '0) && (!in_hi || (lo_q[HALF-1:0] == '0));
        c_flag   = sum[HALF] ^ is_sub;
        v_flag   = (add_a[HALF-1] == add_b[HALF-1]) && (sum[HALF-1] != add_a[HALF-1]);
        // Extended ops can only clear Z, never set it
        z_flag   = is_ext ? (zin_q & res_zero) : res_zero;
    end

    // Sequencer: accept, low pass, optional high pass, result/flags register
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state  <= S_IDLE;
            BUSY   <= 1'b0;
            DONE   <= 1'b0;
            O      <= '0;
            C      <= 1'b0;
            X      <= 1'b0;
            Z      <= 1'b0;
            V      <= 1'b0;
            N      <= 1'b0;
            op_q   <= '0;
            size_q <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
            xin_q  <= 1'b0;
            zin_q  <= 1'b0;
            lo_q   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    DONE <= 1'b0;
                    if (REQ) begin
                        op_q   <= OP;
                        size_q <= SIZE;
                        a_q    <= A;
                        b_q    <= B;
                        xin_q  <= XIN;
                        zin_q  <= ZIN;
                        BUSY   <= 1'b1;
                        state  <= S_LO;
                    end
                end
                S_LO: begin
                    lo_q <= sum;
                    if (size_q) begin
                        state <= S_HI;
                    end else begin
                        state <= S_FIN;
                        DONE  <= 1'b1;
                        O     <= res;
                        C     <= c_flag;
                        X     <= c_flag;
                        Z     <= z_flag;
                        V     <= v_flag;
                        N     <= sum[HALF-1];
                    end
                end
                S_HI: begin
                    state <= S_FIN;
                    DONE  <= 1'b1;
                    O     <= res;
                    C     <= c_flag;
                    X     <= c_flag;
                    Z     <= z_flag;
                    V     <= v_flag;
                    N     <= sum[HALF-1];
                end
                default: begin
                    state <= S_IDLE;
                    DONE  <= 1'b0;
                    BUSY  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Multi-precision sequencer around a registered 16-bit add stage. It executes word (16-bit) and long (32-bit) ADD/SUB/ADDX/SUBX operations. Long operations run as two chained 16-bit passes, low half first, with the carry or borrow propagated between passes. The block sits between the instruction decoder and the register file. It presents a req/busy/done handshake and produces 68000-style CCR flags (X, N, Z, V, C) for the full operand size.

## Interface
Parameters:
- HALF, 16, width of one adder pass; the full operand width is 2*HALF.

Ports:
- CLK  in  1  clock; everything updates on the rising edge.
- RESET  in  1  reset, synchronous, active-high; has priority over all other inputs.
- REQ  in  1  start request; sampled only in IDLE.
- OP  in  2  operation: 00 ADD (A+B), 01 SUB (A−B), 10 ADDX (A+B+XIN), 11 SUBX (A−B−XIN).
- SIZE  in  1  0 = word, 1 = long.
- A, B  in  2*HALF  operands; latched on the accept edge.
- XIN  in  1  extend-flag input for ADDX/SUBX; latched on accept.
- ZIN  in  1  prior Z for ADDX/SUBX sticky-zero rule; latched on accept.
- BUSY  out  1  high in every state except IDLE.
- DONE  out  1  one-cycle pulse; O and the flags are valid and final.
- O  out  2*HALF  result.
- C, X, Z, V, N  out  1 each  condition flags.

## Operation
States: IDLE, LO, HI, FIN.
- IDLE: when REQ=1, latch OP, SIZE, A, B, XIN and ZIN, then go to LO. When REQ=0, stay in IDLE.
- LO: register the 17-bit sum of A[15:0] with B'[15:0] plus cin0. Go to HI if SIZE=1, otherwise go to FIN.
- HI: register the 17-bit sum of A[31:16] with B'[31:16] plus the carry out of LO. Go to FIN.
- FIN: DONE=1. Go to IDLE on the next edge.
- REQ is ignored outside IDLE. There is no queuing; the requester must re-assert after BUSY falls.

Arithmetic:
- Subtract is add-of-complement. B' = ~B for SUB/SUBX; otherwise B' = B.
- cin0 values: ADD 0, ADDX XIN, SUB 1, SUBX ~XIN.
- Let cout be the carry out of the top pass (LO for word, HI for long).
- C = cout for adds and ~cout for subtracts (borrow). X = C.
- N = result MSB: bit 15 for word, bit 31 for long.
- V = (sA == sB') && (sR != sA), where sA, sB' and sR are the sign bits of A, B' and the result at the operand size.
- Z, ADD/SUB: 1 when the result at the operand size is all zeros.
- Z, ADDX/SUBX: ZIN & (result at the operand size is all zeros). Z is cleared on a nonzero result and is never set.
- Word ops: O[31:16] = 0, and flags are derived from bits 15:0 only.

Outputs:
- O and all flags are registered. They update at the transition into FIN and hold until the next FIN.
- They are not valid between accept and DONE.

## Timing
- Accept edge = the rising edge where state=IDLE and REQ=1. BUSY is high from the following cycle.
- Word: DONE is high in the 2nd cycle after accept (edges: accept → LO → FIN).
- Long: DONE is high in the 3rd cycle after accept.
- BUSY falls in the cycle after DONE. The next request can be accepted at the end of that IDLE cycle.
- Back-to-back throughput: word, one op per 3 cycles; long, one op per 4 cycles.
- RESET in any state:
  - next state is IDLE;
  - O = 0 and C, X, Z, V, N = 0;
  - BUSY = 0 and DONE = 0.
  - An operation in flight is discarded and never produces DONE.
- REQ and RESET high together: RESET wins and nothing is accepted.
- Operand inputs may change freely after the accept edge without affecting the result.

## Test plan
- Word ADD, A=0x00007FFF, B=0x00000001 → DONE 2 cycles after accept; O=0x00008000, N=1, V=1, C=0, X=0, Z=0.
- Long ADD, A=0x0000FFFF, B=0x00000001 → DONE 3 cycles after accept; O=0x00010000, C=0, Z=0, N=0, V=0. This checks the carry chain between passes.
- Long SUB, A=0x00000000, B=0x00000001 → O=0xFFFFFFFF, C=1, X=1, N=1, V=0, Z=0.
- Long ADDX, A=0xFFFFFFFF, B=0, XIN=1, ZIN=1 → O=0, C=1, X=1, Z=1.
  - Same with ZIN=0 → Z=0.
  - Word SUBX, A=0x0005, B=0x0005, XIN=0, ZIN=1 → O=0, Z=1, C=0.
- REQ held high continuously with a word op → accepts occur every 3 cycles; BUSY is never low for more than 1 cycle; exactly one DONE per accept.
- RESET asserted while in HI for a long op → next cycle BUSY=0, O=0, all flags 0, no DONE for that op. A fresh word ADD 1+1 then yields O=2 with normal latency.
